// File: rtl/decoder_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_rr_arbiter_4
//  Description : Four-way round-robin arbiter driving a shared 2-to-4 one-hot
//                select path. One owner at a time, bounded hold time with a
//                programmable timeout, mandatory idle cycle between grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_rr_arbiter_4 #(
    parameter int CNT_W    = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // HOLD_MAX of zero disables the timeout; the compare value is then unused.
    localparam bit               c_hold_en   = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

    state_t           r_state;
    logic [3:0]       r_gnt;
    logic [1:0]       r_gnt_idx;
    logic             r_gnt_valid;
    logic             r_timeout;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [1:0]       r_last_idx;

    state_t           w_state_nxt;
    logic [3:0]       w_gnt_nxt;
    logic [1:0]       w_idx_nxt;
    logic             w_valid_nxt;
    logic             w_timeout_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_last_nxt;

    logic [1:0]       w_cand;
    logic [1:0]       w_winner;
    logic             w_found;

    // Pick the first requester after the last winner; scanning from the lowest
    // priority upward lets the highest-priority hit be the final assignment.
    always_comb begin
        w_cand   = '0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_last_idx + 2'(k);
            if (req[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_gnt_idx;
        w_valid_nxt   = r_gnt_valid;
        w_timeout_nxt = 1'b0;
        w_cnt_nxt     = r_hold_cnt;
        w_last_nxt    = r_last_idx;
        case (r_state)
            S_IDLE: begin
                w_valid_nxt = 1'b0;
                if (enable && w_found) begin
                    w_state_nxt = S_GRANT;
                    w_idx_nxt   = w_winner;
                    w_last_nxt  = w_winner;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            S_GRANT: begin
                if (!enable) begin
                    // Abort: no timeout pulse even if the hold limit coincides.
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end else if (!req[r_gnt_idx]) begin
                    // Owner release wins over a simultaneous timeout.
                    w_state_nxt = S_IDLE;
                    w_valid_nxt = 1'b0;
                end else if (c_hold_en && (r_hold_cnt == c_hold_last)) begin
                    w_state_nxt   = S_IDLE;
                    w_valid_nxt   = 1'b0;
                    w_timeout_nxt = 1'b1;
                end else if (r_hold_cnt != c_cnt_max) begin
                    // Saturate rather than wrap when the timeout is disabled.
                    w_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
        w_gnt_nxt = w_valid_nxt ? (4'b0001 << w_idx_nxt) : 4'b0000;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= 4'b0000;
            r_gnt_idx   <= 2'b00;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold_cnt  <= '0;
            r_last_idx  <= 2'b11;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_idx_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_timeout   <= w_timeout_nxt;
            r_hold_cnt  <= w_cnt_nxt;
            r_last_idx  <= w_last_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_rr_arbiter_4
//  Description : Self-checking bench for decoder_rr_arbiter_4 against a
//                behavioural round-robin model (HOLD_MAX = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_rr_arbiter_4;

    localparam int CNT_W    = 8;
    localparam int HOLD_MAX = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the resource, for how many cycles so far.
    bit m_busy;
    int m_idx;
    int m_last;
    int m_len;
    bit m_to;

    decoder_rr_arbiter_4 #(.CNT_W(CNT_W), .HOLD_MAX(HOLD_MAX)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_busy = 1'b0;
        m_idx  = 0;
        m_last = 3;
        m_len  = 0;
        m_to   = 1'b0;
    endfunction

    function automatic void model_step(input bit en, input logic [3:0] r);
        m_to = 1'b0;
        if (!m_busy) begin
            if (en && r != 4'b0000) begin
                for (int k = 1; k <= 4; k++) begin
                    if (r[(m_last + k) % 4]) begin
                        m_idx = (m_last + k) % 4;
                        break;
                    end
                end
                m_last = m_idx;
                m_busy = 1'b1;
                m_len  = 1;
            end
        end else if (!en) begin
            m_busy = 1'b0;
        end else if (!r[m_idx]) begin
            m_busy = 1'b0;
        end else if (HOLD_MAX != 0 && m_len == HOLD_MAX) begin
            m_busy = 1'b0;
            m_to   = 1'b1;
        end else begin
            m_len++;
        end
    endfunction

    // Expected {gnt, gnt_idx, gnt_valid, timeout}.
    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        g = m_busy ? 4'(1 << m_idx) : 4'b0000;
        return {g, 2'(m_idx), m_busy, m_to};
    endfunction

    task automatic step(input bit en, input logic [3:0] r);
        enable = en;
        req    = r;
        @(posedge clk);
        model_step(en, r);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        req    = 4'b1010;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
            failures++;
            $display("FAIL reset_hold: got %b required %b", {gnt, gnt_idx, gnt_valid, timeout}, exp_vec());
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 8'b0) begin
            failures++;
            $display("FAIL reset_release: got %b required %b", {gnt, gnt_idx, gnt_valid, timeout}, 8'b0);
        end
        step(1'b1, 4'b1010);
        checks++;
        if ({gnt, gnt_idx, gnt_valid} !== {4'b0010, 2'd1, 1'b1}) begin
            failures++;
            $display("FAIL first_grant: got %b required %b", {gnt, gnt_idx, gnt_valid}, {4'b0010, 2'd1, 1'b1});
        end
    endtask

    task automatic test_rotation();
        int         order[$];
        int         want[5] = '{0, 1, 2, 3, 0};
        logic [3:0] r;
        bit         prev_valid;
        apply_reset();
        prev_valid = 1'b0;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            r = 4'b1111;
            if (m_busy && m_len == 2) r[m_idx] = 1'b0;
            step(1'b1, r);
            checks++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                failures++;
                $display("FAIL rotation cyc=%0d: got %b required %b", c, {gnt, gnt_idx, gnt_valid, timeout}, exp_vec());
            end
            if (gnt_valid && !prev_valid) order.push_back(int'(gnt_idx));
            prev_valid = gnt_valid;
        end
        checks++;
        if (order.size() != 5) begin
            failures++;
            $display("FAIL rotation_count: got %0d grants required 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (order[i] != want[i]) begin
                    failures++;
                    $display("FAIL rotation_order[%0d]: got %0d required %0d", i, order[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int run;
        int max_run;
        int pulses;
        apply_reset();
        run = 0; max_run = 0; pulses = 0;
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 4'b0001);
            checks++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                failures++;
                $display("FAIL timeout cyc=%0d: got %b required %b", c, {gnt, gnt_idx, gnt_valid, timeout}, exp_vec());
            end
            run = (gnt == 4'b0001) ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (timeout) pulses++;
        end
        checks++;
        if (max_run != HOLD_MAX || pulses != 2) begin
            failures++;
            $display("FAIL timeout_len: got run=%0d pulses=%0d required run=%0d pulses=2", max_run, pulses, HOLD_MAX);
        end
    endtask

    task automatic test_timeout_rotation();
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            step(1'b1, 4'b0011);
            checks++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                failures++;
                $display("FAIL timeout_rot cyc=%0d: got %b required %b", c, {gnt, gnt_idx, gnt_valid, timeout}, exp_vec());
            end
        end
    endtask

    task automatic test_enable_abort();
        apply_reset();
        step(1'b1, 4'b0100);
        step(1'b1, 4'b0100);
        checks++;
        if ({gnt, gnt_idx, gnt_valid} !== {4'b0100, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL abort_setup: got %b required %b", {gnt, gnt_idx, gnt_valid}, {4'b0100, 2'd2, 1'b1});
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 4'b1111);
            checks++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                failures++;
                $display("FAIL abort cyc=%0d: got %b required %b", c, {gnt, gnt_idx, gnt_valid, timeout}, exp_vec());
            end
        end
        step(1'b1, 4'b1111);
        checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== {4'b1000, 2'd3, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL abort_regrant: got %b required %b", {gnt, gnt_idx, gnt_valid, timeout}, {4'b1000, 2'd3, 1'b1, 1'b0});
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(1'b1, 4'b0010);
        step(1'b1, 4'b0010);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 8'b0) begin
            failures++;
            $display("FAIL async_reset: got %b required %b", {gnt, gnt_idx, gnt_valid, timeout}, 8'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 4'b0011);
        checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL async_regrant: got %b required %b", {gnt, gnt_idx, gnt_valid, timeout}, {4'b0001, 2'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        bit         en;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 7) != 0);
            r  = 4'($urandom);
            if (m_busy && $urandom_range(0, 5) != 0) r[m_idx] = 1'b1;
            step(en, r);
            checks++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d: got %b required %b", c, {gnt, gnt_idx, gnt_valid, timeout}, exp_vec());
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        req    = 4'b0000;
        model_reset();
        test_reset();
        test_rotation();
        test_timeout();
        test_timeout_rotation();
        test_enable_abort();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
